btn_conditioner: RTL and testbench
==================================

BTN_CONDITIONER -- requirements
Module: btn_conditioner

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 1_000_000, is the number of cycles a synchronized input must hold a new level before it is accepted (10 ms at 100 MHz).
REQ-002 Parameter HOLD_CYCLES, default 50_000_000, is the number of cycles an edit button must stay accepted-high before auto-repeat starts.
REQ-003 Parameter REPEAT_CYCLES, default 20_000_000, is the auto-repeat period in cycles.
REQ-004 Port `clk`, input, width 1: the single system clock; all logic is on its rising edge.
REQ-005 Port `reset`, input, width 1: synchronous, active-low reset.
REQ-006 Port `raw_mode`, input, width 1: asynchronous mode slide switch (0 = clock, 1 = alarm).
REQ-007 Port `raw_btns`, input, width 2: asynchronous push buttons; bit 1 = hours, bit 0 = minutes.
REQ-008 Port `mode`, output, width 1: conditioned mode level, which feeds the clock/alarm top directly.
REQ-009 Port `edit_btns`, output, width 2: conditioned edit-button levels with auto-repeat; bit order matches `raw_btns`.

Function
REQ-010 Each of the 3 channels SHALL pass its raw input through a 2-flop synchronizer before any other logic.
REQ-011 Debounce rules:
- Each channel holds an accepted level and a counter.
- The counter clears whenever the synchronized value equals the accepted level.
- Otherwise the counter increments.
- When the counter reaches DEBOUNCE_CYCLES-1, the accepted level takes the synchronized value and the counter clears.
REQ-012 A glitch shorter than DEBOUNCE_CYCLES cycles SHALL leave the accepted level unchanged.
REQ-013 When a raw input changes and then stays stable, the output SHALL change exactly 2+DEBOUNCE_CYCLES rising edges after the change is first sampled.
REQ-014 `mode` SHALL equal the accepted level of its channel; it has no auto-repeat.
REQ-015 Each edit channel SHALL run an FSM with states IDLE, HELD and REPEAT, and one cycle counter.
REQ-016 IDLE transitions and output:
- Output is 0.
- On an accepted rising level, go to HELD, clear the counter, and drive output 1 in that same cycle.
REQ-017 HELD transitions and output:
- Output is 1 and the counter increments.
- When the counter reaches HOLD_CYCLES-1, drive output 0 for exactly one cycle, clear the counter, and go to REPEAT.
REQ-018 REPEAT transitions and output:
- Output is 1 except for one 0 cycle each time the counter reaches REPEAT_CYCLES-1.
- The counter clears at each 0 cycle, so every rising edge of the output is a fresh edit event for the downstream edge detector.
REQ-019 An accepted falling level in HELD or REPEAT SHALL force output 0 and return the FSM to IDLE in the same cycle; this takes priority over any repeat pulse due in that cycle.
REQ-020 The two edit channels are fully independent; pressing both buttons together SHALL give two independent repeat trains.
REQ-021 Counter widths SHALL be $clog2 of the relevant parameter, and counters SHALL never wrap.

Reset
REQ-022 While `reset` is 0 at a clock edge, the following SHALL be cleared at that edge:
- synchronizer flops, accepted levels and all counters go to 0;
- FSMs go to IDLE;
- `mode` = 0 and `edit_btns` = 2'b00.
REQ-023 If reset is released while a button is held, that button SHALL require a full debounce interval before its output rises; reset does not preserve any state.

Structure
REQ-024 Package `btn_pkg` SHALL hold the FSM state enum {IDLE, HELD, REPEAT} and the three default cycle constants.
REQ-025 Sub-module `debounce_channel` (sync + debounce, 1 bit) SHALL be instantiated 3 times.
REQ-026 The repeat FSM SHALL live in btn_conditioner as one generate loop over the 2 edit channels.

Verification (bench parameters: DEBOUNCE=4, HOLD=10, REPEAT=5)
REQ-027 Reset and steady press:
- Stimulus: hold `reset`=0 for 3 cycles, release it, then set raw_btns=2'b01 and keep it stable.
- Response: outputs read 0 during reset; edit_btns[0] rises 6 edges after the press is sampled.
REQ-028 Bounce rejection:
- Stimulus: raw_btns[1] toggles with high times of 1, 2 and 3 cycles, then settles at 0.
- Response: edit_btns[1] stays 0 throughout.
REQ-029 Auto-repeat train:
- Stimulus: hold raw_btns[0]=1 for 40 cycles.
- Response: single-cycle 0 pulses at 10, 15, 20, ... cycles after the output first rises.
REQ-030 Release collision:
- Stimulus: accepted release lands in the same cycle a repeat pulse is due.
- Response: output goes to 0, the FSM returns to IDLE, and no further rising edge occurs.
REQ-031 Reset mid-hold:
- Stimulus: pull `reset` low during REPEAT while the button stays pressed, then release reset.
- Response: outputs are 0, and the output rises again 6 edges later.
REQ-032 Mode channel:
- Stimulus: raw_mode 0 -> 1 with both edit buttons held.
- Response: `mode` rises 6 edges later with no pulses on `mode`, and the edit repeat trains are unaffected.

Source files
------------

// File: rtl/btn_pkg.sv
// Shared definitions for the button conditioner.
// Contents:
//   - default cycle counts for debounce, hold-before-repeat and repeat period
//   - state type for the per-button auto-repeat FSM
//   - counter width helper, so a parameter of 1 still yields a 1-bit counter
package btn_pkg;

    // 10 ms debounce, 500 ms hold-off and 200 ms repeat period at 100 MHz
    localparam int unsigned DEBOUNCE_CYCLES_DEF = 32'd1_000_000;
    localparam int unsigned HOLD_CYCLES_DEF     = 32'd50_000_000;
    localparam int unsigned REPEAT_CYCLES_DEF   = 32'd20_000_000;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HELD   = 2'd1,
        REPEAT = 2'd2
    } btn_state_e;

    // Bits needed to count 0 .. cycles-1, never less than one bit
    function automatic int unsigned cnt_width(input int unsigned cycles);
        return (cycles > 32'd1) ? $clog2(cycles) : 32'd1;
    endfunction

endpackage

// File: rtl/btn_conditioner_debounce.sv
// debounce_channel: one asynchronous input made safe for the clk domain.
// Ports:
//   clk   - system clock, rising edge
//   reset - synchronous, active-low
//   raw   - asynchronous input (switch or push button)
//   level - accepted (debounced) level, registered
// The raw input goes through two synchronizer flops; the debouncer only ever
// looks at the second flop. A new level is accepted once it has been seen for
// DEBOUNCE_CYCLES consecutive cycles; any return to the accepted level
// restarts the count.
module debounce_channel
    import btn_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic level
);

    localparam int unsigned   CW       = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 32'd1);
    localparam logic [CW-1:0] CNT_ZERO = CW'(32'd0);
    localparam logic [CW-1:0] CNT_ONE  = CW'(32'd1);

    logic          sync1_r;
    logic          sync2_r;
    logic          level_r;
    logic [CW-1:0] cnt_r;

    // Two-flop synchronizer for the asynchronous input
    always_ff @(posedge clk) begin
        if (!reset) begin
            sync1_r <= 1'b0;
            sync2_r <= 1'b0;
        end else begin
            sync1_r <= raw;
            sync2_r <= sync1_r;
        end
    end

    // Stability counter and accepted level; the count clears at acceptance so it never wraps
    always_ff @(posedge clk) begin
        if (!reset) begin
            level_r <= 1'b0;
            cnt_r   <= CNT_ZERO;
        end else if (sync2_r == level_r) begin
            cnt_r   <= CNT_ZERO;
        end else if (cnt_r == CNT_LAST) begin
            level_r <= sync2_r;
            cnt_r   <= CNT_ZERO;
        end else begin
            cnt_r   <= cnt_r + CNT_ONE;
        end
    end

    assign level = level_r;

endmodule

// File: rtl/btn_conditioner.sv
// btn_conditioner: conditions the mode switch and the two edit buttons of the
// clock/alarm front panel.
// Ports:
//   clk       - system clock, rising edge
//   reset     - synchronous, active-low
//   raw_mode  - asynchronous mode switch (0 = clock, 1 = alarm)
//   raw_btns  - asynchronous push buttons, [1] = hours, [0] = minutes
//   mode      - debounced mode level, registered
//   edit_btns - debounced button levels with auto-repeat, registered
// While an edit button is held the output stays high for HOLD_CYCLES, then
// drops low for one cycle every REPEAT_CYCLES. Each low-to-high transition is
// treated downstream as one more edit step.
module btn_conditioner
    import btn_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int unsigned HOLD_CYCLES     = HOLD_CYCLES_DEF,
    parameter int unsigned REPEAT_CYCLES   = REPEAT_CYCLES_DEF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       raw_mode,
    input  logic [1:0] raw_btns,
    output logic       mode,
    output logic [1:0] edit_btns
);

    // One counter serves both the hold-off and the repeat period
    localparam int unsigned   CW = cnt_width((HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES
                                                                           : REPEAT_CYCLES);
    localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 32'd1);
    localparam logic [CW-1:0] REP_LAST  = CW'(REPEAT_CYCLES - 32'd1);
    localparam logic [CW-1:0] CNT_ZERO  = CW'(32'd0);
    localparam logic [CW-1:0] CNT_ONE   = CW'(32'd1);

    logic       mode_level_s;
    logic [1:0] btn_level_s;
    logic       mode_r;

    debounce_channel #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_mode_db (
        .clk   (clk),
        .reset (reset),
        .raw   (raw_mode),
        .level (mode_level_s)
    );

    debounce_channel #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_min_db (
        .clk   (clk),
        .reset (reset),
        .raw   (raw_btns[0]),
        .level (btn_level_s[0])
    );

    debounce_channel #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_hour_db (
        .clk   (clk),
        .reset (reset),
        .raw   (raw_btns[1]),
        .level (btn_level_s[1])
    );

    // Registered mode output; one cycle behind the accepted level so it lines up with edit_btns
    always_ff @(posedge clk) begin
        if (!reset) begin
            mode_r <= 1'b0;
        end else begin
            mode_r <= mode_level_s;
        end
    end

    assign mode = mode_r;

    for (genvar g = 0; g < 2; g++) begin : g_edit
        btn_state_e    state_r;
        btn_state_e    state_s;
        logic [CW-1:0] cnt_r;
        logic [CW-1:0] cnt_s;
        logic          out_r;
        logic          out_s;

        // Next-state logic; a release always wins over a repeat pulse due in the same cycle
        always_comb begin
            state_s = state_r;
            cnt_s   = cnt_r;
            out_s   = 1'b0;
            case (state_r)
                IDLE: begin
                    if (btn_level_s[g]) begin
                        state_s = HELD;
                        cnt_s   = CNT_ZERO;
                        out_s   = 1'b1;
                    end else begin
                        state_s = IDLE;
                        cnt_s   = CNT_ZERO;
                        out_s   = 1'b0;
                    end
                end
                HELD: begin
                    if (!btn_level_s[g]) begin
                        state_s = IDLE;
                        cnt_s   = CNT_ZERO;
                        out_s   = 1'b0;
                    end else if (cnt_r == HOLD_LAST) begin
                        state_s = REPEAT;
                        cnt_s   = CNT_ZERO;
                        out_s   = 1'b0;
                    end else begin
                        state_s = HELD;
                        cnt_s   = cnt_r + CNT_ONE;
                        out_s   = 1'b1;
                    end
                end
                REPEAT: begin
                    if (!btn_level_s[g]) begin
                        state_s = IDLE;
                        cnt_s   = CNT_ZERO;
                        out_s   = 1'b0;
                    end else if (cnt_r == REP_LAST) begin
                        state_s = REPEAT;
                        cnt_s   = CNT_ZERO;
                        out_s   = 1'b0;
                    end else begin
                        state_s = REPEAT;
                        cnt_s   = cnt_r + CNT_ONE;
                        out_s   = 1'b1;
                    end
                end
                default: begin
                    state_s = IDLE;
                    cnt_s   = CNT_ZERO;
                    out_s   = 1'b0;
                end
            endcase
        end

        // State, counter and registered edit output
        always_ff @(posedge clk) begin
            if (!reset) begin
                state_r <= IDLE;
                cnt_r   <= CNT_ZERO;
                out_r   <= 1'b0;
            end else begin
                state_r <= state_s;
                cnt_r   <= cnt_s;
                out_r   <= out_s;
            end
        end

        assign edit_btns[g] = out_r;
    end

endmodule

// File: tb/tb_btn_conditioner.sv
// Self-checking bench for btn_conditioner with DEBOUNCE=4, HOLD=10, REPEAT=5.
// Every clock edge a model derived from the raw-input history pushes the
// expected {mode, edit_btns} for that edge; the monitor pops and compares on
// the following falling edge.
module tb_btn_conditioner;

    localparam int DB  = 4;
    localparam int HLD = 10;
    localparam int REP = 5;
    localparam int LAT = DB + 2;   // sampled press to output edge

    logic       clk;
    logic       reset;
    logic       raw_mode;
    logic [1:0] raw_btns;
    logic       mode;
    logic [1:0] edit_btns;

    btn_conditioner #(
        .DEBOUNCE_CYCLES (DB),
        .HOLD_CYCLES     (HLD),
        .REPEAT_CYCLES   (REP)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .raw_mode  (raw_mode),
        .raw_btns  (raw_btns),
        .mode      (mode),
        .edit_btns (edit_btns)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int         n_checks = 0;
    int         n_errors = 0;
    int         cyc      = 0;
    string      phase    = "reset";
    logic [2:0] sb_q[$];

    // Per channel (0 = minutes, 1 = hours, 2 = mode): edge a stable press / release was first sampled
    int   p_e[3]  = '{-1, -1, -1};
    int   q_e[3]  = '{-1, -1, -1};
    logic prev[3] = '{1'b0, 1'b0, 1'b0};

    task automatic check_val(input string tag, input logic [2:0] got, input logic [2:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s edge %0d: {mode,edit_btns} got %b expected %b", tag, cyc, got, exp);
        end
    endtask

    function automatic logic exp_edit(input int p, input int q, input int n);
        int t;
        if (p < 0 || n < p + LAT) return 1'b0;
        if (q >= 0 && n >= q + LAT) return 1'b0;
        t = n - (p + LAT);
        if (t >= HLD && ((t - HLD) % REP) == 0) return 1'b0;
        return 1'b1;
    endfunction

    function automatic logic exp_mode(input int p, input int q, input int n);
        if (p < 0 || n < p + LAT) return 1'b0;
        if (q >= 0 && n >= q + LAT) return 1'b0;
        return 1'b1;
    endfunction

    // Reference model: track sampled raw transitions and push the expected outputs for this edge
    always @(posedge clk) begin
        logic [2:0] rawv;
        logic [2:0] expv;
        cyc  = cyc + 1;
        rawv = {raw_mode, raw_btns};
        for (int i = 0; i < 3; i++) begin
            if (!reset) begin
                p_e[i]  = -1;
                q_e[i]  = -1;
                prev[i] = 1'b0;
            end else if (rawv[i] != prev[i]) begin
                if (rawv[i]) begin
                    p_e[i] = cyc;
                    q_e[i] = -1;
                end else if (p_e[i] >= 0 && (cyc - p_e[i]) < DB) begin
                    p_e[i] = -1;     // high too short: never accepted
                    q_e[i] = -1;
                end else begin
                    q_e[i] = cyc;
                end
                prev[i] = rawv[i];
            end
        end
        expv[0] = exp_edit(p_e[0], q_e[0], cyc);
        expv[1] = exp_edit(p_e[1], q_e[1], cyc);
        expv[2] = exp_mode(p_e[2], q_e[2], cyc);
        sb_q.push_back(expv);
    end

    // Monitor: compare DUT outputs half a cycle after each edge
    always @(negedge clk) begin
        if (sb_q.size() > 0) begin
            check_val(phase, {mode, edit_btns}, sb_q.pop_front());
        end
    end

    task automatic tick(input int k);
        repeat (k) @(posedge clk);
        #1;
    endtask

    initial begin
        reset    = 1'b0;
        raw_mode = 1'b0;
        raw_btns = 2'b00;

        phase = "reset";
        tick(3);
        reset = 1'b1;
        tick(2);

        phase = "press_repeat";
        raw_btns = 2'b01;
        tick(60);
        raw_btns = 2'b00;
        tick(12);

        // release sampled 15 edges after press: accepted fall meets the 2nd repeat pulse
        phase = "release_collision";
        raw_btns = 2'b01;
        tick(15);
        raw_btns = 2'b00;
        tick(20);

        phase = "bounce";
        for (int h = 1; h <= 3; h++) begin
            raw_btns = 2'b10;
            tick(h);
            raw_btns = 2'b00;
            tick(4);
        end
        tick(10);

        phase = "min_press";
        raw_btns = 2'b10;
        tick(DB);
        raw_btns = 2'b00;
        tick(12);

        phase = "reset_mid_hold";
        raw_btns = 2'b01;
        tick(30);
        reset = 1'b0;
        tick(2);
        reset = 1'b1;
        tick(25);
        raw_btns = 2'b00;
        tick(12);

        phase = "mode";
        raw_btns = 2'b11;
        tick(3);
        raw_mode = 1'b1;
        tick(45);
        raw_btns = 2'b00;
        tick(12);
        raw_mode = 1'b0;
        tick(12);

        @(negedge clk);
        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
